// File: rtl/b06_eql_driver.sv
// rtl/b06_eql_driver.sv - b06 interrupt-handler requester: four-phase EQL/ACKOUT handshake with timeout.
// Optional ENABLE_COUNT cycle counter on EN_CYCLES is built when B06_EQL_DRIVER_ENCOUNT_EN is defined.
module b06_eql_driver #(
  parameter int TMO_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             START,
  input  logic             REQ_CONT,
  input  logic             ACKOUT,
  input  logic [1:0]       USCITE,
  input  logic [1:0]       CC_MUX,
  input  logic             ENABLE_COUNT,
  output logic             EQL,
  output logic             CONT_EQL,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR,
  output logic [1:0]       CAP_USCITE,
  output logic [1:0]       CAP_CC_MUX,
  output logic [CNT_W-1:0] XACT_CNT,
  output logic [CNT_W-1:0] EN_CYCLES
);

  typedef enum logic [2:0] {
    IDLE, ASSERT, WAIT_HI, RELEASE, WAIT_LO, FINISH, FAIL
  } state_t;

  localparam logic [TMO_W-1:0] TMO_MAX = '1;
  localparam logic [TMO_W-1:0] TMO_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state;
  logic [TMO_W-1:0] tmo;
  logic [TMO_W-1:0] tmo_inc;
  logic             req_cont_q;

  // Saturating increment: the counter parks at the compare value.
  assign tmo_inc = (tmo == TMO_MAX) ? tmo : tmo + TMO_ONE;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= IDLE;
      tmo        <= '0;
      req_cont_q <= 1'b0;
      EQL        <= 1'b0;
      CONT_EQL   <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERROR      <= 1'b0;
      CAP_USCITE <= '0;
      CAP_CC_MUX <= '0;
      XACT_CNT   <= '0;
    end else begin
      DONE  <= 1'b0;
      ERROR <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            req_cont_q <= REQ_CONT;
            tmo        <= '0;
            BUSY       <= 1'b1;
            state      <= ASSERT;
          end
        end
        ASSERT: begin
          EQL      <= 1'b1;
          CONT_EQL <= req_cont_q;
          state    <= WAIT_HI;
        end
        WAIT_HI: begin
          if (ACKOUT) begin
            CAP_USCITE <= USCITE;
            CAP_CC_MUX <= CC_MUX;
            tmo        <= '0;
            state      <= RELEASE;
          end else begin
            tmo <= tmo_inc;
            if (tmo_inc == TMO_MAX) begin
              EQL      <= 1'b0;
              CONT_EQL <= 1'b0;
              ERROR    <= 1'b1;
              state    <= FAIL;
            end
          end
        end
        RELEASE: begin
          EQL      <= 1'b0;
          CONT_EQL <= 1'b0;
          state    <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!ACKOUT) begin
            DONE     <= 1'b1;
            XACT_CNT <= XACT_CNT + CNT_ONE;
            state    <= FINISH;
          end else begin
            tmo <= tmo_inc;
            if (tmo_inc == TMO_MAX) begin
              ERROR <= 1'b1;
              state <= FAIL;
            end
          end
        end
        default: begin
          // FINISH and FAIL: pulse already visible this cycle, head home.
          EQL      <= 1'b0;
          CONT_EQL <= 1'b0;
          BUSY     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef B06_EQL_DRIVER_ENCOUNT_EN
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      EN_CYCLES <= '0;
    end else if (state == IDLE && START) begin
      EN_CYCLES <= '0;
    end else if (BUSY && ENABLE_COUNT && EN_CYCLES != CNT_MAX) begin
      EN_CYCLES <= EN_CYCLES + CNT_ONE;
    end
  end
`else
  logic unused_enable_count;
  assign unused_enable_count = ENABLE_COUNT;
  assign EN_CYCLES = '0;
`endif

endmodule

// File: tb/tb_b06_eql_driver.sv
// tb/tb_b06_eql_driver.sv - self-checking bench for b06_eql_driver against a transaction-timeline model.
module tb_b06_eql_driver;
  localparam int TMO_W  = 4;
  localparam int CNT_W  = 2;
  localparam int CNT_M  = 4;
  localparam int EN_MAX = 3;

  logic             CLOCK = 1'b0;
  logic             RESET, START, REQ_CONT, ACKOUT, ENABLE_COUNT;
  logic [1:0]       USCITE, CC_MUX;
  logic             EQL, CONT_EQL, BUSY, DONE, ERROR;
  logic [1:0]       CAP_USCITE, CAP_CC_MUX;
  logic [CNT_W-1:0] XACT_CNT, EN_CYCLES;

  int checks = 0;
  int errors = 0;
  int exp_xact = 0;
  int exp_en = 0;
  logic [1:0] exp_cu = 2'b00;
  logic [1:0] exp_cc = 2'b00;

  b06_eql_driver #(.TMO_W(TMO_W), .CNT_W(CNT_W)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .REQ_CONT(REQ_CONT),
    .ACKOUT(ACKOUT), .USCITE(USCITE), .CC_MUX(CC_MUX), .ENABLE_COUNT(ENABLE_COUNT),
    .EQL(EQL), .CONT_EQL(CONT_EQL), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
    .CAP_USCITE(CAP_USCITE), .CAP_CC_MUX(CAP_CC_MUX),
    .XACT_CNT(XACT_CNT), .EN_CYCLES(EN_CYCLES)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk1(input string tag, input int cyc, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic chkv(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic int en_model(input int v);
`ifdef B06_EQL_DRIVER_ENCOUNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // Cycle 0 carries START. ACKOUT is high for cycles [a, f). The model derives
  // the acknowledge sample cycle h, the release sample cycle l and the
  // cycle endc on which DONE or ERROR appears, then checks every cycle.
  task automatic run_xact(input bit rc, input int a, input int f, input logic [63:0] en_bits,
                          input bit fixed, input logic [1:0] fu, input logic [1:0] fc);
    int h, l, endc, eql_last, en_acc;
    bit hi_ok, lo_ok, ok;
    logic [1:0] u, cm, cu_new, cc_new;
    h        = (a > 2) ? a : 2;
    hi_ok    = (h <= 2 + (2**TMO_W - 2)) && (h < f);
    l        = (f > h + 2) ? f : h + 2;
    lo_ok    = (l <= h + 2 + (2**TMO_W - 2));
    ok       = hi_ok && lo_ok;
    endc     = !hi_ok ? 2 + (2**TMO_W - 1) : (lo_ok ? l + 1 : h + 2 + (2**TMO_W - 1));
    eql_last = hi_ok ? h + 1 : 1 + (2**TMO_W - 1);
    en_acc   = 0;
    cu_new   = 2'b00;
    cc_new   = 2'b00;
    for (int c = 0; c <= endc + 1; c++) begin
      if (hi_ok && c == h + 1) begin
        exp_cu = cu_new;
        exp_cc = cc_new;
      end
      if (ok && c == endc) exp_xact = (exp_xact + 1) % CNT_M;
      chk1("eql", c, EQL, c >= 2 && c <= eql_last);
      chk1("cont_eql", c, CONT_EQL, rc && c >= 2 && c <= eql_last);
      chk1("busy", c, BUSY, c >= 1 && c <= endc);
      chk1("done", c, DONE, ok && c == endc);
      chk1("error", c, ERROR, !ok && c == endc);
      chkv("cap_uscite", c, 32'(CAP_USCITE), 32'(exp_cu));
      chkv("cap_cc_mux", c, 32'(CAP_CC_MUX), 32'(exp_cc));
      chkv("xact_cnt", c, 32'(XACT_CNT), exp_xact);
      chkv("en_cycles", c, 32'(EN_CYCLES), en_model(c == 0 ? exp_en : en_acc));
      START        = (c == 0) ? 1'b1 : (c <= endc ? 1'($urandom_range(0, 1)) : 1'b0);
      REQ_CONT     = (c == 0) ? rc : 1'($urandom_range(0, 1));
      ACKOUT       = (c >= a && c < f);
      ENABLE_COUNT = en_bits[c];
      u            = fixed ? fu : 2'($urandom);
      cm           = fixed ? fc : 2'($urandom);
      USCITE       = u;
      CC_MUX       = cm;
      if (c == h) begin
        cu_new = u;
        cc_new = cm;
      end
      if (c >= 1 && c <= endc && en_bits[c] && en_acc < EN_MAX) en_acc++;
      step();
    end
    exp_en = en_acc;
  endtask

  task automatic chk_reset_state(input string tag);
    chk1({tag, "_eql"}, 0, EQL, 1'b0);
    chk1({tag, "_cont"}, 0, CONT_EQL, 1'b0);
    chk1({tag, "_busy"}, 0, BUSY, 1'b0);
    chk1({tag, "_done"}, 0, DONE, 1'b0);
    chk1({tag, "_error"}, 0, ERROR, 1'b0);
    chkv({tag, "_cap_u"}, 0, 32'(CAP_USCITE), 0);
    chkv({tag, "_cap_c"}, 0, 32'(CAP_CC_MUX), 0);
    chkv({tag, "_xact"}, 0, 32'(XACT_CNT), 0);
    chkv({tag, "_en"}, 0, 32'(EN_CYCLES), 0);
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; REQ_CONT = 1'b0; ACKOUT = 1'b0;
    ENABLE_COUNT = 1'b0; USCITE = 2'b00; CC_MUX = 2'b00;
    step();
    step();
    chk_reset_state("reset");
    RESET = 1'b0;
    step();

    // Basic handshake: ACKOUT 3 cycles after EQL rises, drops 2 after EQL falls.
    run_xact(1'b0, 5, 9, 64'h0, 1'b1, 2'b10, 2'b01);
    chkv("basic_cap_u", 0, 32'(CAP_USCITE), 32'h2);
    chkv("basic_cap_c", 0, 32'(CAP_CC_MUX), 32'h1);
    chkv("basic_xact", 0, 32'(XACT_CNT), 32'h1);
    run_xact(1'b1, 3, 7, 64'h0, 1'b0, 2'b00, 2'b00);
    run_xact(1'b0, 2, 3, 64'h0, 1'b0, 2'b00, 2'b00);
    run_xact(1'b1, 100, 200, 64'h0, 1'b0, 2'b00, 2'b00);
    run_xact(1'b1, 0, 1000, 64'h0, 1'b0, 2'b00, 2'b00);
    run_xact(1'b0, 16, 20, 64'h0, 1'b0, 2'b00, 2'b00);
    run_xact(1'b0, 17, 30, 64'h0, 1'b0, 2'b00, 2'b00);
    run_xact(1'b1, 2, 18, 64'h0, 1'b0, 2'b00, 2'b00);
    run_xact(1'b1, 2, 19, 64'h0, 1'b0, 2'b00, 2'b00);

    // Reset while waiting for the acknowledge with EQL high.
    START = 1'b1; REQ_CONT = 1'b1; ACKOUT = 1'b0;
    step();
    START = 1'b0;
    step();
    step();
    chk1("mid_eql_before", 2, EQL, 1'b1);
    RESET = 1'b1;
    step();
    chk_reset_state("mid_reset");
    RESET = 1'b0;
    exp_xact = 0; exp_en = 0; exp_cu = 2'b00; exp_cc = 2'b00;
    step();
    step();

    // Five good transactions with ENABLE_COUNT high 3 cycles each; counter wraps.
    for (int i = 0; i < 5; i++) begin
      int a0;
      a0 = $urandom_range(2, 6);
      run_xact(1'($urandom_range(0, 1)), a0, a0 + $urandom_range(1, 5), 64'hE, 1'b0, 2'b00, 2'b00);
    end
    chkv("wrap_xact", 0, 32'(XACT_CNT), 32'h1);
    chkv("wrap_en", 0, 32'(EN_CYCLES), en_model(3));

    for (int i = 0; i < 40; i++) begin
      int a0;
      a0 = $urandom_range(0, 18);
      run_xact(1'($urandom_range(0, 1)), a0, ((a0 > 2) ? a0 : 2) + $urandom_range(0, 19),
               {$urandom, $urandom}, 1'b0, 2'b00, 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
